// File: rtl/lsu_mem_initiator_if.sv
// Memory-side bus between the load/store unit (master) and the 64-bit-word main memory (slave).
interface lsu_mem_initiator_if;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/lsu_mem_initiator.sv
// Memory-stage load/store initiator: alignment/funct3 checks, load extraction, sub-doubleword RMW stores.
// Optional: define LSU_RANGE_CHECK_EN to reject doubleword indices >= DEPTH with err_code 10.
module lsu_mem_initiator #(
    parameter int DEPTH      = 32,
    parameter int IDX_W      = 5,
    parameter int MEM_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [63:0] base,
    input  logic [63:0] imm,
    input  logic [63:0] rs2_data,
    output logic        busy,
    output logic        done,
    output logic [1:0]  err_code,
    output logic [63:0] load_data,
    lsu_mem_initiator_if.master mem
);

    localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR      = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;
    localparam logic [2:0] S_ERR     = 3'd5;

    logic [2:0]       state;
    logic [IDX_W+2:0] ea_q;
    logic [2:0]       f3_q;
    logic             store_q;
    logic [63:0]      rs2_q;
    logic [63:0]      rbuf_q;
    logic [63:0]      load_data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       err_q;

    logic [63:0] ea;
    logic        illegal;
    logic        misaligned;
    logic        out_of_range;
    logic        unused_ea_hi;

    assign ea = base + imm;
    assign unused_ea_hi = &{1'b0, ea[63:IDX_W+3]};

`ifdef LSU_RANGE_CHECK_EN
    assign out_of_range = (ea[63:3] >= 61'(DEPTH));
`else
    assign out_of_range = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        illegal    = (is_load == is_store) || (is_load && funct3 == 3'b111) || (is_store && funct3[2]);
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = ea[0];
            2'b10:   misaligned = |ea[1:0];
            2'b11:   misaligned = |ea[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    // Load field extraction works straight off the returning doubleword.
    logic [63:0] rd_shift;
    logic [63:0] load_ext;

    always_comb begin
        rd_shift = mem.mem_rdata >> {ea_q[2:0], 3'b000};
        case (f3_q)
            3'b000:  load_ext = {{56{rd_shift[7]}},  rd_shift[7:0]};
            3'b001:  load_ext = {{48{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  load_ext = {{32{rd_shift[31]}}, rd_shift[31:0]};
            3'b100:  load_ext = {56'd0, rd_shift[7:0]};
            3'b101:  load_ext = {48'd0, rd_shift[15:0]};
            3'b110:  load_ext = {32'd0, rd_shift[31:0]};
            default: load_ext = rd_shift;
        endcase
    end

    // Store merge: an sd has a full mask at lane 0, so it degenerates to rs2 unchanged.
    logic [63:0] size_mask;
    logic [63:0] lane_mask;
    logic [63:0] merged;

    always_comb begin
        case (f3_q[1:0])
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        lane_mask = size_mask << {ea_q[2:0], 3'b000};
        merged    = (rbuf_q & ~lane_mask) | ((rs2_q << {ea_q[2:0], 3'b000}) & lane_mask);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            ea_q    <= '0;
            f3_q    <= '0;
            store_q <= 1'b0;
            rs2_q   <= '0;
            rbuf_q  <= '0;
            cnt_q   <= '0;
            err_q   <= 2'b00;
            // An abort keeps the last completed load result; a reset from idle clears it.
            if (state != S_IDLE) load_data_q <= load_data_q;
            else                 load_data_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        ea_q    <= ea[IDX_W+2:0];
                        f3_q    <= funct3;
                        store_q <= is_store;
                        rs2_q   <= rs2_data;
                        if (illegal) begin
                            err_q <= 2'b11;
                            state <= S_ERR;
                        end else if (misaligned) begin
                            err_q <= 2'b01;
                            state <= S_ERR;
                        end else if (out_of_range) begin
                            err_q <= 2'b10;
                            state <= S_ERR;
                        end else if (is_store && funct3 == 3'b011) begin
                            err_q <= 2'b00;
                            state <= S_WR;
                        end else begin
                            err_q <= 2'b00;
                            state <= S_RD_REQ;
                        end
                    end
                end
                S_RD_REQ: begin
                    cnt_q <= CNT_W'(MEM_RD_LAT - 1);
                    state <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        rbuf_q <= mem.mem_rdata;
                        if (store_q) begin
                            state <= S_WR;
                        end else begin
                            load_data_q <= load_ext;
                            state       <= S_DONE;
                        end
                    end
                end
                S_WR:    state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    logic rd_strobe;
    logic wr_strobe;

    assign rd_strobe = (state == S_RD_REQ) && !rst;
    assign wr_strobe = (state == S_WR) && !rst;

    assign mem.mem_read  = rd_strobe;
    assign mem.mem_write = wr_strobe;
    assign mem.mem_addr  = (rd_strobe || wr_strobe) ? {{(64 - IDX_W){1'b0}}, ea_q[IDX_W+2:3]} : 64'd0;
    assign mem.mem_wdata = wr_strobe ? merged : 64'd0;

    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE || state == S_ERR) && !rst;
    assign err_code  = (state == S_ERR && !rst) ? err_q : 2'b00;
    assign load_data = load_data_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Self-checking bench for lsu_mem_initiator: directed cases plus randomized ops against a byte-level memory model.
module tb_lsu_mem_initiator;
    localparam int DEPTH      = 32;
    localparam int IDX_W      = 5;
    localparam int MEM_RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [63:0] base = 64'd0;
    logic [63:0] imm = 64'd0;
    logic [63:0] rs2_data = 64'd0;
    logic        busy;
    logic        done;
    logic [1:0]  err_code;
    logic [63:0] load_data;

    always #5 clk = ~clk;

    lsu_mem_initiator_if mem_if ();

    lsu_mem_initiator #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .MEM_RD_LAT(MEM_RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
        .funct3(funct3), .base(base), .imm(imm), .rs2_data(rs2_data),
        .busy(busy), .done(done), .err_code(err_code), .load_data(load_data),
        .mem(mem_if.master)
    );

    // Environment memory: one-cycle registered read, plus a backdoor for preloading.
    logic [63:0] env_mem [DEPTH];
    logic        bd_we = 1'b0;
    int          bd_idx = 0;
    logic [63:0] bd_val = 64'd0;

    always @(posedge clk) begin
        if (bd_we) env_mem[bd_idx] <= bd_val;
        if (mem_if.mem_write) env_mem[mem_if.mem_addr[IDX_W-1:0]] <= mem_if.mem_wdata;
        if (mem_if.mem_read) mem_if.mem_rdata <= env_mem[mem_if.mem_addr[IDX_W-1:0]];
    end

    // Reference memory as plain little-endian bytes.
    logic [7:0]  ref_b [DEPTH*8];
    logic [63:0] exp_ld = 64'd0;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        logic [1:0]  err;
        int          lat;
        int          rd;
        int          wr;
        logic [63:0] addr;
        logic [63:0] ld;
        logic [63:0] word;
        bit          load_ok;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] ref_word(input int w);
        logic [63:0] v = 64'd0;
        for (int j = 0; j < 8; j++) v[8*j +: 8] = ref_b[w*8 + j];
        return v;
    endfunction

    task automatic set_word(input int w, input logic [63:0] v);
        for (int j = 0; j < 8; j++) ref_b[w*8 + j] = v[8*j +: 8];
        bd_we = 1'b1;
        bd_idx = w;
        bd_val = v;
        @(negedge clk);
        bd_we = 1'b0;
    endtask

    function automatic exp_t model(input bit ld_op, input bit st_op, input logic [2:0] f3,
                                   input logic [63:0] ea, input logic [63:0] rs2);
        exp_t e;
        int size, lane, baddr, w;
        bit illegal, mis, oor;
        size    = 1 << f3[1:0];
        lane    = int'(ea % 64'd8);
        illegal = (ld_op == st_op) || (ld_op && f3 == 3'b111) || (st_op && f3 > 3'd3);
        mis     = (size > 1) && (ea % 64'(size) != 64'd0);
`ifdef LSU_RANGE_CHECK_EN
        oor = (ea >> 3) >= 64'(DEPTH);
`else
        oor = 1'b0;
`endif
        e.err = illegal ? 2'b11 : mis ? 2'b01 : oor ? 2'b10 : 2'b00;
        e.addr = (ea >> 3) % 64'(DEPTH);
        w = int'(e.addr);
        baddr = w*8 + lane;
        e.ld = 64'd0;
        e.word = 64'd0;
        e.load_ok = 1'b0;
        e.rd = 0;
        e.wr = 0;
        if (e.err != 2'b00) begin
            e.lat = 1;
        end else if (st_op) begin
            e.wr  = 1;
            e.rd  = (size == 8) ? 0 : 1;
            e.lat = (size == 8) ? 2 : 4;
            for (int j = 0; j < 8; j++)
                e.word[8*j +: 8] = (j >= lane && j < lane + size) ? rs2[8*(j-lane) +: 8] : ref_b[w*8 + j];
        end else begin
            e.rd = 1;
            e.lat = 3;
            e.load_ok = 1'b1;
            for (int i = 0; i < size; i++) e.ld = e.ld | (64'(ref_b[baddr + i]) << (8*i));
            if (!f3[2] && size < 8 && e.ld[8*size-1]) e.ld = e.ld | (~64'd0 << (8*size));
        end
        return e;
    endfunction

    // Issue one request and watch it cycle by cycle; poke_k pulses a junk start, rst_k asserts reset.
    task automatic run_op(input string tag, input bit ld_op, input bit st_op, input logic [2:0] f3,
                          input logic [63:0] b, input logic [63:0] im, input logic [63:0] rs2,
                          input int poke_k, input int rst_k);
        exp_t e;
        logic [63:0] ea, rd_a, wr_a, wr_d, ld_seen;
        logic [1:0] err_seen;
        int rd_n, wr_n, rd_k, wr_k, done_k, both_n;
        bit seen_done;
        ea = b + im;
        e = model(ld_op, st_op, f3, ea, rs2);
        rd_n = 0; wr_n = 0; rd_k = 0; wr_k = 0; done_k = 0; both_n = 0; seen_done = 1'b0;
        rd_a = 64'd0; wr_a = 64'd0; wr_d = 64'd0; ld_seen = 64'd0; err_seen = 2'b00;
        is_load = ld_op; is_store = st_op; funct3 = f3; base = b; imm = im; rs2_data = rs2;
        start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 20; k++) begin
            start = 1'b0;
            if (mem_if.mem_read) begin rd_n++; rd_k = k; rd_a = mem_if.mem_addr; end
            if (mem_if.mem_write) begin wr_n++; wr_k = k; wr_a = mem_if.mem_addr; wr_d = mem_if.mem_wdata; end
            if (mem_if.mem_read && mem_if.mem_write) both_n++;
            if (done) begin seen_done = 1'b1; done_k = k; err_seen = err_code; ld_seen = load_data; end
            if (rst_k != 0 && k == rst_k + 1) begin
                check({tag, ".busy_after_rst"}, 64'(busy), 64'd0);
                rst = 1'b0;
                break;
            end
            if (seen_done) break;
            if (k == poke_k) begin
                is_load = 1'b0; is_store = 1'b1; funct3 = 3'b011; base = 64'd0; imm = 64'd0;
                rs2_data = 64'hDEAD_BEEF_0BAD_F00D; start = 1'b1;
            end
            if (k == rst_k) rst = 1'b1;
            @(negedge clk);
        end
        check({tag, ".overlap"}, 64'(both_n), 64'd0);
        if (rst_k != 0) begin
            check({tag, ".no_done"}, 64'(seen_done), 64'd0);
            check({tag, ".no_write"}, 64'(wr_n), 64'd0);
            check({tag, ".ld_held"}, load_data, exp_ld);
        end else begin
            check({tag, ".done_seen"}, 64'(seen_done), 64'd1);
            check({tag, ".latency"}, 64'(done_k), 64'(e.lat));
            check({tag, ".err"}, 64'(err_seen), 64'(e.err));
            check({tag, ".rd_cnt"}, 64'(rd_n), 64'(e.rd));
            check({tag, ".wr_cnt"}, 64'(wr_n), 64'(e.wr));
            if (e.rd != 0) begin
                check({tag, ".rd_cycle"}, 64'(rd_k), 64'd1);
                check({tag, ".rd_addr"}, rd_a, e.addr);
            end
            if (e.wr != 0) begin
                check({tag, ".wr_cycle"}, 64'(wr_k), 64'(e.lat - 1));
                check({tag, ".wr_addr"}, wr_a, e.addr);
                check({tag, ".wr_data"}, wr_d, e.word);
                for (int j = 0; j < 8; j++) ref_b[int'(e.addr)*8 + j] = e.word[8*j +: 8];
            end
            if (e.load_ok) exp_ld = e.ld;
            check({tag, ".load_data"}, ld_seen, exp_ld);
            @(negedge clk);
            check({tag, ".idle_after"}, 64'({busy, done}), 64'd0);
        end
    endtask

    initial begin
        logic [63:0] ea, rb;
        int sel, size, w, lane;
        logic [2:0] f3;
        bit ld_op, st_op;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.err_code", 64'(err_code), 64'd0);
        check("rst.load_data", load_data, 64'd0);
        check("rst.strobes", 64'({mem_if.mem_read, mem_if.mem_write}), 64'd0);
        check("rst.mem_addr", mem_if.mem_addr, 64'd0);
        check("rst.mem_wdata", mem_if.mem_wdata, 64'd0);

        for (int i = 0; i < DEPTH; i++) set_word(i, {$urandom, $urandom});
        set_word(2, 64'h1122_3344_5566_7788);

        run_op("ld", 1, 0, 3'b011, 64'h10, 64'h0, 64'd0, 0, 0);
        check("ld.value", load_data, 64'h1122_3344_5566_7788);
        run_op("lb", 1, 0, 3'b000, 64'h8, 64'h8, 64'd0, 0, 0);
        check("lb.value", load_data, 64'hFFFF_FFFF_FFFF_FF88);
        run_op("lbu", 1, 0, 3'b100, 64'h18, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 0, 0);
        check("lbu.value", load_data, 64'h88);
        run_op("lh", 1, 0, 3'b001, 64'h16, 64'h0, 64'd0, 0, 0);
        check("lh.value", load_data, 64'h1122);
        run_op("lw", 1, 0, 3'b010, 64'h14, 64'h0, 64'd0, 0, 0);
        check("lw.value", load_data, 64'h1122_3344);
        run_op("sb", 0, 1, 3'b000, 64'h11, 64'h0, 64'h0000_0000_0000_00AB, 0, 0);
        run_op("ld_merged", 1, 0, 3'b011, 64'h10, 64'h0, 64'd0, 0, 0);
        check("merged.value", load_data, 64'h1122_3344_5566_AB88);
        run_op("lw_mis", 1, 0, 3'b010, 64'h12, 64'h0, 64'd0, 0, 0);
        run_op("sd_far", 0, 1, 3'b011, 64'h100, 64'h0, {$urandom, $urandom}, 0, 0);
        run_op("ill_both", 1, 1, 3'b011, 64'h10, 64'h0, 64'd0, 0, 0);
        run_op("ill_none", 0, 0, 3'b000, 64'h10, 64'h0, 64'd0, 0, 0);
        run_op("ill_ld111", 1, 0, 3'b111, 64'h10, 64'h0, 64'd0, 0, 0);
        run_op("ill_st100", 0, 1, 3'b100, 64'h10, 64'h0, 64'd0, 0, 0);
        run_op("sh_rst", 0, 1, 3'b001, 64'h20, 64'h2, 64'h0000_0000_0000_BEEF, 0, 2);
        run_op("ld_poke", 1, 0, 3'b011, 64'h18, 64'h0, 64'd0, 1, 0);
        run_op("sb_poke", 0, 1, 3'b000, 64'h28, 64'h5, 64'h0000_0000_0000_005A, 2, 0);

        for (int n = 0; n < 200; n++) begin
            f3 = 3'($urandom_range(0, 7));
            size = 1 << f3[1:0];
            w = $urandom_range(0, 2*DEPTH - 1);
            lane = $urandom_range(0, 7);
            if ($urandom_range(0, 3) != 0) lane = lane & ~(size - 1);
            ea = 64'(w) * 64'd8 + 64'(lane);
            if ($urandom_range(0, 15) == 0) ea[63:40] = 24'($urandom);
            sel = $urandom_range(0, 15);
            if (sel == 0) begin ld_op = 1; st_op = 1; end
            else if (sel == 1) begin ld_op = 0; st_op = 0; end
            else begin ld_op = sel[0]; st_op = !sel[0]; end
            rb = {$urandom, $urandom};
            run_op("rand", ld_op, st_op, f3, rb, ea - rb, {$urandom, $urandom},
                   ($urandom_range(0, 7) == 0) ? 1 : 0, 0);
        end

        for (int i = 0; i < DEPTH; i++) check("final_mem", env_mem[i], ref_word(i));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_mem_initiator.md
Name: lsu_mem_initiator

Overview:
- Load/store unit that initiates every ld/sd-family access to the 64-bit-word main memory during the memory stage.
- Computes the byte address, checks alignment, range and funct3, and drives the memory's read/write strobes, doubleword index and store data.
- Captures load data and extracts/sign-extends it, and performs read-modify-write for sub-doubleword stores, because memory writes whole doublewords only.

Parameters:
- DEPTH, 32, number of 64-bit doublewords in main memory.
- IDX_W, 5, index width; must equal clog2(DEPTH).
- MEM_RD_LAT, 1, cycles from the sampled mem_read edge until mem_rdata is valid; must be at least 1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted only in IDLE.
- is_load  in  1  request is a load.
- is_store  in  1  request is a store.
- funct3  in  3  RV64 load/store funct3.
- base  in  64  rs1 value.
- imm  in  64  sign-extended offset.
- rs2_data  in  64  store source.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- err_code  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal operation; valid while done=1.
- load_data  out  64  extended load result; held until the next load completes.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_addr  out  64  doubleword index, zero-extended.
- mem_wdata  out  64  store data to memory.
- mem_rdata  in  64  memory read data.

Behaviour:
- Reset values: all outputs 0, state IDLE, latched registers 0.
- ea = base + imm, modulo 2^64. idx = ea >> 3. Byte lane = ea[2:0]. Memory is little-endian: byte k occupies bits [8k+7:8k].
- Loads: funct3 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu. Any other load funct3 is illegal.
- Stores: funct3 000 sb, 001 sh, 010 sw, 011 sd. Any other store funct3 is illegal.
- Illegal operation: is_load==is_store with start=1 in IDLE, or an illegal funct3.
- Misaligned: the access size is greater than 1 and ea[2:0] is not a multiple of the size.
- IDLE:
  - On start: latch ea, funct3, op and rs2_data.
  - Error priority is illegal (11), then misaligned (01), then out of range (10). On any error, go to ERR.
  - Otherwise: sd goes to WR; every load and every sb/sh/sw goes to RD_REQ.
- RD_REQ: mem_read=1 and mem_addr=idx for exactly 1 cycle. Load counter with MEM_RD_LAT-1, then go to RD_WAIT.
- RD_WAIT:
  - While the counter is nonzero, decrement it.
  - At 0, sample mem_rdata into rbuf.
  - For a load, go to DONE with load_data registered from the extracted field (sign-extended or zero-extended).
  - For a store, go to WR.
- WR: mem_write=1, mem_addr=idx, for 1 cycle. mem_wdata is rs2_data (sd), or rbuf with the lane bytes replaced by the low 1/2/4 bytes of rs2_data. Then go to DONE.
- DONE: done=1, err_code=00, for 1 cycle, then IDLE.
- ERR: done=1 with err_code set, for 1 cycle, then IDLE. Neither strobe is asserted for the request.
- Latency with MEM_RD_LAT=1, start at cycle T: sd done at T+2; loads done at T+3; sb/sh/sw done at T+4; errors done at T+1.
- Strobes are decoded from state and gated with !rst, so no access is made in a reset cycle.
- mem_read and mem_write are never high together. Both are 0 outside RD_REQ/WR.
- mem_addr and mem_wdata are 0 when no strobe is active.
- start while busy: ignored, no queueing.
- rst mid-operation: state is IDLE after the edge, any pending write is dropped, done does not pulse, load_data keeps its value.
- is_load/is_store/funct3/base/imm/rs2_data are sampled only on the accepting edge; later changes have no effect.

Optional Feature:
- LSU_RANGE_CHECK_EN defined: idx >= DEPTH produces err_code 10 with no memory access.
- LSU_RANGE_CHECK_EN undefined: code 10 is never produced; mem_addr = idx[IDX_W-1:0], wrapping modulo DEPTH.

Test Plan:
- mem[2]=0x1122334455667788; ld with base=0x10, imm=0 -> mem_read at T+1 with mem_addr=2; done at T+3 with load_data=0x1122334455667788 and err_code=00.
- Same mem[2]:
  - lb with ea=0x10 -> 0xFFFFFFFFFFFFFF88.
  - lbu with ea=0x10 -> 0x88.
  - lh with ea=0x16 -> 0x1122.
  - lw with ea=0x14 -> 0x11223344.
- sb with rs2_data=0xAB and ea=0x11 -> mem_read at T+1, mem_write at T+3, mem_wdata=0x112233445566AB88, done at T+4; a subsequent ld of index 2 returns the merged value.
- lw with ea=0x12 -> done at T+1 with err_code=01; mem_read and mem_write stay 0; memory unchanged.
- sd with ea=0x100 and DEPTH=32:
  - With LSU_RANGE_CHECK_EN: done at T+1 with err_code=10 and no write.
  - Without: mem[0] is written with rs2_data.
- Illegal operation and reset/busy handling:
  - start with is_load=is_store=1 -> err_code=11.
  - sh with rst asserted during RD_WAIT -> no mem_write, busy=0 next cycle.
  - start pulsed while busy -> no effect.
